// File: rtl/fetch_unit_p.sv
// LC-3 fetch stage: resolves the pending PC redirect, reads instruction
// memory with MEM_LAT clocks of latency, captures IR and bumps the PC.
module fetch_unit_p #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  input  logic [3:0]        opCode_in,
  input  logic              jsr_mode_in,
  input  logic [10:0]       offset_in,
  input  logic [DATA_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wea_out,
  output logic              mem_en_out,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] r7_out,
  output logic              r7_we,
  output logic              fetch_done,
  output logic              busy
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, CAPT, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          first;

  logic              br_op;
  logic              jmp_op;
  logic              jsr_op;
  logic              r7_hit;
  logic [ADDR_W-1:0] sext9;
  logic [ADDR_W-1:0] sext11;
  logic [ADDR_W-1:0] reg_tgt;
  logic [ADDR_W-1:0] redir_pc;

  assign wea_out = 1'b0;

  assign br_op  = (opCode_in == 4'b0000);
  assign jmp_op = (opCode_in == 4'b1100);
  assign jsr_op = (opCode_in == 4'b0100);

  assign sext9   = {{(ADDR_W-9){offset_in[8]}}, offset_in[8:0]};
  assign sext11  = {{(ADDR_W-11){offset_in[10]}}, offset_in};
  assign reg_tgt = ADDR_W'(reg_in);

  always_comb begin
    redir_pc = pc;
    r7_hit   = 1'b0;
    unique case (1'b1)
      br_op: begin
        if (|(br_nzp & result_nzp))
          redir_pc = pc + sext9;
      end
      jmp_op: redir_pc = reg_tgt;
      jsr_op: begin
        r7_hit   = 1'b1;
        redir_pc = jsr_mode_in ? pc + sext11 : reg_tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      first      <= 1'b1;
      pc         <= RESET_PC;
      addr_out   <= '0;
      ir_out     <= '0;
      r7_out     <= '0;
      mem_en_out <= 1'b0;
      r7_we      <= 1'b0;
      fetch_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_en_out <= 1'b0;
      r7_we      <= 1'b0;
      fetch_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_start) begin
            first      <= 1'b0;
            busy       <= 1'b1;
            mem_en_out <= 1'b1;
            state      <= REQ;
            // Nothing has executed yet after reset, so no redirect.
            if (first) begin
              addr_out <= pc;
            end else begin
              pc       <= redir_pc;
              addr_out <= redir_pc;
              if (r7_hit) begin
                r7_out <= pc;
                r7_we  <= 1'b1;
              end
            end
          end
        end
        REQ: begin
          if (MEM_LAT == 1) begin
            state <= CAPT;
          end else begin
            state <= WAIT;
            cnt   <= CW'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt <= CW'(1))
            state <= CAPT;
          else
            cnt <= cnt - CW'(1);
        end
        CAPT: begin
          ir_out     <= mem_rdata;
          pc         <= pc + ADDR_W'(1);
          fetch_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit_p.sv
// Bench for fetch_unit_p: two instances (MEM_LAT 1 and 3) checked every
// cycle against a timeline model, plus literal spot checks.
module tb_fetch_unit_p;

  localparam int L1 = 1;
  localparam int L3 = 3;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] ir;
    logic [15:0] ir_prev;
    logic [15:0] r7;
    logic [15:0] tgt;
    bit          first;
    bit          act;
    bit          jsr;
    int          t0;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        fs1 = 1'b0;
  logic        fs3 = 1'b0;
  logic [3:0]  op = '0;
  logic        jsr_mode = 1'b0;
  logic [10:0] off = '0;
  logic [15:0] reg_in = '0;
  logic [2:0]  br_nzp = '0;
  logic [2:0]  res_nzp = '0;

  logic [15:0] rd1, addr1, ir1, pc1, r71;
  logic        wea1, en1, we1, done1, busy1;
  logic [15:0] rd3, addr3, ir3, pc3, r73;
  logic        wea3, en3, we3, done3, busy3;

  logic [15:0] mem [0:65535];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  int   lat_of [2];
  mdl_t m [2];
  int   lat;

  fetch_unit_p #(.MEM_LAT(L1)) u1 (
    .clk(clk), .rst_n(rst_n), .fetch_start(fs1),
    .opCode_in(op), .jsr_mode_in(jsr_mode), .offset_in(off),
    .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(res_nzp),
    .mem_rdata(rd1), .addr_out(addr1), .wea_out(wea1),
    .mem_en_out(en1), .ir_out(ir1), .pc(pc1), .r7_out(r71),
    .r7_we(we1), .fetch_done(done1), .busy(busy1)
  );

  fetch_unit_p #(.MEM_LAT(L3)) u3 (
    .clk(clk), .rst_n(rst_n), .fetch_start(fs3),
    .opCode_in(op), .jsr_mode_in(jsr_mode), .offset_in(off),
    .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(res_nzp),
    .mem_rdata(rd3), .addr_out(addr3), .wea_out(wea3),
    .mem_en_out(en3), .ir_out(ir3), .pc(pc3), .r7_out(r73),
    .r7_we(we3), .fetch_done(done3), .busy(busy3)
  );

  // Memory: data is valid only in the single cycle MEM_LAT after the request.
  logic [15:0] ra1 = '0;
  logic [15:0] ra3 = '0;
  int          lc1 = 0;
  int          lc3 = 0;
  logic        p1 = 1'b0;
  logic        p3 = 1'b0;

  always @(posedge clk) begin
    if (en1) begin
      ra1 <= addr1; lc1 <= L1 - 1; p1 <= 1'b1;
    end else if (lc1 != 0) lc1 <= lc1 - 1;
    else p1 <= 1'b0;
  end

  always @(posedge clk) begin
    if (en3) begin
      ra3 <= addr3; lc3 <= L3 - 1; p3 <= 1'b1;
    end else if (lc3 != 0) lc3 <= lc3 - 1;
    else p3 <= 1'b0;
  end

  assign rd1 = (p1 && lc1 == 0) ? mem[ra1] : 16'hDEAD;
  assign rd3 = (p3 && lc3 == 0) ? mem[ra3] : 16'hDEAD;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int a);
    logic [15:0] v;
    v = 16'(a);
    return {v[7:0], v[15:8]} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] redirect(input logic [15:0] p);
    logic [15:0] s9;
    logic [15:0] s11;
    s9  = off[8]  ? 16'(int'(off[8:0]) - 512) : 16'(off[8:0]);
    s11 = off[10] ? 16'(int'(off) - 2048)     : 16'(off);
    if (op == OP_BR)
      return ((br_nzp & res_nzp) != 3'b000) ? p + s9 : p;
    if (op == OP_JMP) return reg_in;
    if (op == OP_JSR) return jsr_mode ? p + s11 : reg_in;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m[i].pc = 16'h0000;
    m[i].addr = '0;
    m[i].ir = '0;
    m[i].ir_prev = '0;
    m[i].r7 = '0;
    m[i].tgt = '0;
    m[i].first = 1'b1;
    m[i].act = 1'b0;
    m[i].jsr = 1'b0;
    m[i].t0 = 0;
  endtask

  task automatic model_start(input int i);
    m[i].ir_prev = m[i].ir;
    m[i].tgt = m[i].first ? m[i].pc : redirect(m[i].pc);
    m[i].jsr = !m[i].first && (op == OP_JSR);
    if (m[i].jsr) m[i].r7 = m[i].pc;
    m[i].addr = m[i].tgt;
    m[i].ir = mem[m[i].tgt];
    m[i].pc = m[i].tgt + 16'd1;
    m[i].first = 1'b0;
    m[i].act = 1'b1;
    m[i].t0 = cyc;
  endtask

  // k = cycle number after the accepting edge (REQ is cycle 1).
  task automatic cmp(input int i,
                     input logic [15:0] g_pc, input logic [15:0] g_addr,
                     input logic [15:0] g_ir, input logic [15:0] g_r7,
                     input logic g_busy, input logic g_en,
                     input logic g_done, input logic g_we,
                     input logic g_wea);
    int    k;
    bit    pre;
    bit    live;
    string s;
    s = (i == 0) ? "u1_" : "u3_";
    k = cyc - m[i].t0 + 1;
    live = m[i].act && k <= lat_of[i] + 2;
    pre = m[i].act && k <= lat_of[i] + 1;
    chk({s, "pc"}, g_pc, pre ? m[i].tgt : m[i].pc);
    chk({s, "addr"}, g_addr, m[i].addr);
    chk({s, "ir"}, g_ir, pre ? m[i].ir_prev : m[i].ir);
    chk({s, "r7"}, g_r7, m[i].r7);
    chkb({s, "busy"}, g_busy, live);
    chkb({s, "mem_en"}, g_en, m[i].act && k == 1);
    chkb({s, "done"}, g_done, m[i].act && k == lat_of[i] + 2);
    chkb({s, "r7_we"}, g_we, m[i].act && m[i].jsr && k == 1);
    chkb({s, "wea"}, g_wea, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, pc1, addr1, ir1, r71, busy1, en1, done1, we1, wea1);
      cmp(1, pc3, addr3, ir3, r73, busy3, en3, done3, we3, wea3);
    end
  end

  task automatic launch(input int i, input logic [3:0] o,
                        input logic jm, input logic [10:0] of,
                        input logic [15:0] rv, input logic [2:0] bn,
                        input logic [2:0] rn);
    @(posedge clk); #1;
    op = o; jsr_mode = jm; off = of;
    reg_in = rv; br_nzp = bn; res_nzp = rn;
    if (i == 0) fs1 = 1'b1; else fs3 = 1'b1;
    @(posedge clk); #1;
    fs1 = 1'b0; fs3 = 1'b0;
    model_start(i);
  endtask

  task automatic finish_fetch(input int i, output int lt);
    lt = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if ((i == 0) ? done1 : done3) begin
        lt = cyc - m[i].t0 + 1;
        break;
      end
    end
    if (lt < 0) begin
      n_chk++; n_fail++;
      $display("FAIL u%0d_done_timeout got=none exp=pulse", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int i, input logic [3:0] o,
                       input logic jm, input logic [10:0] of,
                       input logic [15:0] rv, input logic [2:0] bn,
                       input logic [2:0] rn, input bit poke,
                       output int lt);
    launch(i, o, jm, of, rv, bn, rn);
    if (poke) begin
      @(posedge clk); #1;
      if (i == 0) fs1 = 1'b1; else fs3 = 1'b1;
      @(posedge clk); #1;
      fs1 = 1'b0; fs3 = 1'b0;
    end
    finish_fetch(i, lt);
  endtask

  task automatic jmp(input int i, input logic [15:0] t);
    int lt;
    fetch(i, OP_JMP, 1'b0, 11'h000, t, 3'b000, 3'b000, 1'b0, lt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = pat(a);
    mem[0] = 16'h1234;
    lat_of[0] = L1;
    lat_of[1] = L3;
    model_reset(0);
    model_reset(1);
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_addr", addr1, 16'h0000);
    chkb("rst_wea", wea1, 1'b0);
    chk("rst_pc", pc1, 16'h0000);
    chkb("rst_busy", busy1, 1'b0);
    chkb("rst_done", done1, 1'b0);

    // First fetch ignores the pending JMP.
    fetch(0, OP_JMP, 1'b0, 11'h000, 16'h7777, 3'b000, 3'b000, 1'b0, lat);
    chk("seq1_lat", 16'(lat), 16'd3);
    chk("seq1_addr", addr1, 16'h0000);
    chk("seq1_ir", ir1, 16'h1234);
    chk("seq1_pc", pc1, 16'h0001);
    fetch(0, OP_ADD, 1'b0, 11'h000, 16'h0000, 3'b000, 3'b000, 1'b0, lat);
    chk("seq2_addr", addr1, 16'h0001);
    chk("seq2_pc", pc1, 16'h0002);

    jmp(0, 16'h0004);
    chk("jmp_pc5", pc1, 16'h0005);
    fetch(0, OP_BR, 1'b0, 11'h1FE, 16'h0000, 3'b010, 3'b010, 1'b0, lat);
    chk("br_tk_addr", addr1, 16'h0003);
    chk("br_tk_pc", pc1, 16'h0004);
    jmp(0, 16'h0004);
    fetch(0, OP_BR, 1'b0, 11'h1FE, 16'h0000, 3'b010, 3'b100, 1'b0, lat);
    chk("br_nt_addr", addr1, 16'h0005);
    fetch(0, OP_BR, 1'b0, 11'h1FE, 16'h0000, 3'b000, 3'b111, 1'b0, lat);
    chk("br_000_addr", addr1, 16'h0006);
    fetch(0, OP_BR, 1'b0, 11'h0FF, 16'h0000, 3'b001, 3'b001, 1'b0, lat);
    chk("br_pos_addr", addr1, 16'h0106);

    jmp(0, 16'h2FFF);
    fetch(0, OP_JMP, 1'b0, 11'h000, 16'h4000, 3'b000, 3'b000, 1'b0, lat);
    chk("jmp_addr", addr1, 16'h4000);
    chk("jmp_pc", pc1, 16'h4001);
    jmp(0, 16'h2FFF);
    fetch(0, OP_JSR, 1'b1, 11'h010, 16'h0000, 3'b000, 3'b000, 1'b0, lat);
    chk("jsr_r7", r71, 16'h3000);
    chk("jsr_addr", addr1, 16'h3010);
    jmp(0, 16'h2FFF);
    fetch(0, OP_JSR, 1'b0, 11'h000, 16'h5000, 3'b000, 3'b000, 1'b0, lat);
    chk("jsrr_addr", addr1, 16'h5000);
    chk("jsrr_r7", r71, 16'h3000);
    fetch(0, OP_JSR, 1'b1, 11'h7FF, 16'h0000, 3'b000, 3'b000, 1'b0, lat);
    chk("jsr_neg_addr", addr1, 16'h5000);
    chk("jsr_neg_r7", r71, 16'h5001);

    jmp(0, 16'hFFFE);
    fetch(0, OP_ADD, 1'b0, 11'h000, 16'h0000, 3'b000, 3'b000, 1'b0, lat);
    chk("wrap_addr", addr1, 16'hFFFF);
    chk("wrap_pc", pc1, 16'h0000);

    fetch(1, OP_ADD, 1'b0, 11'h000, 16'h0000, 3'b000, 3'b000, 1'b0, lat);
    chk("lat3_lat", 16'(lat), 16'd5);
    chk("lat3_addr", addr3, 16'h0000);
    chk("lat3_ir", ir3, 16'h1234);
    fetch(1, OP_JMP, 1'b0, 11'h000, 16'h0010, 3'b000, 3'b000, 1'b1, lat);
    chk("poke_lat", 16'(lat), 16'd5);
    chk("poke_addr", addr3, 16'h0010);
    chk("poke_pc", pc3, 16'h0011);

    // Abort in WAIT, then confirm the next fetch starts at RESET_PC.
    launch(1, OP_JMP, 1'b0, 11'h000, 16'h0200, 3'b000, 3'b000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("abort_pc", pc3, 16'h0000);
    chk("abort_ir", ir3, 16'h0000);
    chk("abort_addr", addr3, 16'h0000);
    chkb("abort_busy", busy3, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fetch(1, OP_JMP, 1'b0, 11'h000, 16'h1234, 3'b000, 3'b000, 1'b0, lat);
    chk("post_addr", addr3, 16'h0000);
    chk("post_pc", pc3, 16'h0001);
    chk("post_ir", ir3, 16'h1234);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
